// File: rtl/hub75_scan_ctrl.sv
`default_nettype none
// hub75_scan_ctrl: HUB75 bit-plane shifter and BCM row/OE sequencer; the next plane shifts while the current one is displayed.
// Optional macro HUB75_GLOBAL_DIM_EN adds a brightness[7:0] input that shortens the OE-low part of each display window.
module hub75_scan_ctrl #(
   parameter int COLS     = 32,
   parameter int ROW_BITS = 3,
   parameter int BPC      = 4,
   parameter int BASE_OE  = 8
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                enable,
`ifdef HUB75_GLOBAL_DIM_EN
   input  logic [7:0]                          brightness,
`endif
   output logic                                pix_req,
   output logic [ROW_BITS-1:0]                 pix_row,
   output logic [$clog2(COLS)-1:0]             pix_col,
   output logic [((BPC > 1) ? $clog2(BPC) : 1)-1:0] pix_plane,
   input  logic [5:0]                          pix_rgb,
   output logic                                hub75_clk,
   output logic                                hub75_lat,
   output logic                                hub75_oe_,
   output logic [ROW_BITS-1:0]                 hub75_row,
   output logic                                hub75_r0,
   output logic                                hub75_g0,
   output logic                                hub75_b0,
   output logic                                hub75_r1,
   output logic                                hub75_g1,
   output logic                                hub75_b1,
   output logic                                frame_start
);

   localparam int COL_W = $clog2(COLS);
   localparam int PL_W  = (BPC > 1) ? $clog2(BPC) : 1;
   localparam int K_W   = COL_W + 2;
   localparam int CNT_W = $clog2(BASE_OE << (BPC - 1)) + 1;
   localparam logic [K_W-1:0]  K_LAST  = K_W'(2 * COLS);
   localparam logic [PL_W-1:0] PL_LAST = PL_W'(BPC - 1);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} sh_state_t;
   typedef enum logic [2:0] {IDLE, SHIFT_WAIT, BLANK, LATCH, DISPLAY} fr_state_t;

   sh_state_t           sh_state, sh_next;
   fr_state_t           fr_state, fr_next;
   logic [K_W-1:0]      k;
   logic [ROW_BITS-1:0] sp_row, nxt_row, start_row;
   logic [PL_W-1:0]     sp_plane, nxt_plane, start_plane, disp_plane;
   logic [CNT_W-1:0]    disp_cnt, on_cnt, win_len, on_len;
   logic                stop_req;
   logic                start_shift, abort_shift, consume_shift, advance, rewind;

   assign pix_req   = (sh_state == S_SHIFT) && !k[0] && (k != K_LAST);
   assign pix_col   = k[COL_W:1];
   assign pix_row   = sp_row;
   assign pix_plane = sp_plane;

   always_comb begin
      nxt_row   = sp_row;
      nxt_plane = sp_plane + PL_W'(1);
      if (sp_plane == PL_LAST) begin
         nxt_plane = '0;
         nxt_row   = sp_row + ROW_BITS'(1);
      end
      start_row   = advance ? nxt_row : sp_row;
      start_plane = advance ? nxt_plane : sp_plane;
   end

   assign win_len = CNT_W'(BASE_OE) << disp_plane;

`ifdef HUB75_GLOBAL_DIM_EN
   logic [7:0]       bright_q;
   logic [CNT_W+7:0] dim_prod;
   assign dim_prod = (CNT_W + 8)'(win_len) * (CNT_W + 8)'(bright_q);
   assign on_len   = dim_prod[CNT_W+7:8];
`else
   assign on_len   = win_len;
`endif

   // Frame sequencer: a window must fully expire before the next row/plane is latched.
   always_comb begin
      fr_next       = fr_state;
      start_shift   = 1'b0;
      abort_shift   = 1'b0;
      consume_shift = 1'b0;
      advance       = 1'b0;
      rewind        = 1'b0;
      case (fr_state)
         IDLE: begin
            if (enable) begin
               start_shift = 1'b1;
               fr_next     = SHIFT_WAIT;
            end
         end
         SHIFT_WAIT: begin
            if (disp_cnt == '0) begin
               if (stop_req || !enable) begin
                  abort_shift = 1'b1;
                  rewind      = 1'b1;
                  fr_next     = IDLE;
               end else if (sh_state == S_DONE) begin
                  fr_next = BLANK;
               end
            end
         end
         BLANK:   fr_next = LATCH;
         LATCH: begin
            consume_shift = 1'b1;
            fr_next       = DISPLAY;
         end
         DISPLAY: begin
            advance     = 1'b1;
            start_shift = enable;
            fr_next     = SHIFT_WAIT;
         end
         default: fr_next = IDLE;
      endcase
   end

   always_comb begin
      sh_next = sh_state;
      if (abort_shift) begin
         sh_next = S_IDLE;
      end else if (start_shift) begin
         sh_next = S_SHIFT;
      end else begin
         case (sh_state)
            S_SHIFT: if (k == K_LAST) sh_next = S_DONE;
            S_DONE:  if (consume_shift) sh_next = S_IDLE;
            default: sh_next = sh_state;
         endcase
      end
   end

   // Odd cycles capture fetched data, so the following even cycle presents it with a rising shift clock.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sh_state  <= S_IDLE;
         k         <= '0;
         hub75_clk <= 1'b0;
         {hub75_b1, hub75_g1, hub75_r1, hub75_b0, hub75_g0, hub75_r0} <= '0;
      end else begin
         sh_state  <= sh_next;
         hub75_clk <= (sh_state == S_SHIFT) && k[0] && !abort_shift;
         if (start_shift) begin
            k <= '0;
         end else if ((sh_state == S_SHIFT) && (k != K_LAST)) begin
            k <= k + K_W'(1);
         end
         if ((sh_state == S_SHIFT) && k[0]) begin
            {hub75_b1, hub75_g1, hub75_r1, hub75_b0, hub75_g0, hub75_r0} <= pix_rgb;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fr_state    <= IDLE;
         sp_row      <= '0;
         sp_plane    <= '0;
         disp_plane  <= '0;
         hub75_row   <= '0;
         hub75_lat   <= 1'b0;
         hub75_oe_   <= 1'b1;
         disp_cnt    <= '0;
         on_cnt      <= '0;
         stop_req    <= 1'b0;
         frame_start <= 1'b0;
`ifdef HUB75_GLOBAL_DIM_EN
         bright_q    <= '0;
`endif
      end else begin
         fr_state    <= fr_next;
         hub75_lat   <= (fr_next == LATCH);
         frame_start <= start_shift && (start_row == '0) && (start_plane == '0);
         if (rewind) begin
            sp_row   <= '0;
            sp_plane <= '0;
         end else if (advance) begin
            sp_row   <= nxt_row;
            sp_plane <= nxt_plane;
         end
         if (fr_state == LATCH) begin
            hub75_row  <= sp_row;
            disp_plane <= sp_plane;
`ifdef HUB75_GLOBAL_DIM_EN
            bright_q   <= brightness;
`endif
         end
         if (fr_state == DISPLAY) begin
            disp_cnt  <= win_len;
            on_cnt    <= on_len;
            hub75_oe_ <= (on_len == '0);
            stop_req  <= !enable;
         end else begin
            if (disp_cnt != '0) disp_cnt <= disp_cnt - CNT_W'(1);
            if (on_cnt != '0)   on_cnt   <= on_cnt - CNT_W'(1);
            if (on_cnt <= CNT_W'(1)) hub75_oe_ <= 1'b1;
            if (rewind) stop_req <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire
